// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver and its baud tick generator.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK_WAIT
    } rx_state_t;

    // Clocks per oversample tick; 0 marks an unreachable rate so the caller can stop elaboration.
    function automatic int calc_tick_div(input int clk_freq, input int baud_rate, input int oversample);
        int div;
        if (baud_rate < 1 || oversample < 1) begin
            return 0;
        end
        div = clk_freq / (baud_rate * oversample);
        return (div < 1) ? 0 : div;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator with a restart input so a frame can align to its start edge.
module uart_baud_tick #(
    parameter int TICK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_reg <= '0;
        end else if (restart || cnt_reg == CNT_LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // Suppressed during restart so the first tick of a frame is a full period away.
    assign tick = (cnt_reg == CNT_LAST) && !restart;

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: 5..9 data bits, optional parity, 1/2 stop bits, break detection
// and a valid/ready output with overrun reporting.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx_line,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 break_det
);

    localparam int TICK_DIV = calc_tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int OS_W     = $clog2(OVERSAMPLE);
    localparam int BIT_W    = 4;

    localparam logic [OS_W-1:0]  OS_VOTE0 = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  OS_VOTE1 = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0]  OS_VOTE2 = OS_W'(OVERSAMPLE / 2 + 1);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    if (TICK_DIV < 1) begin : g_bad_tick_div
        $error("uart_rx_param: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx_param: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_rx_param: STOP_BITS must be 1 or 2");
    end
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
        $error("uart_rx_param: OVERSAMPLE must be even and at least 8");
    end
    if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
        $error("uart_rx_param: PARITY must be 0, 1 or 2");
    end

    logic                 rx_meta_reg, rx_s_reg, rx_prev_reg;
    rx_state_t            state_reg, state_next;
    logic [OS_W-1:0]      os_cnt_reg;
    logic [BIT_W-1:0]     bit_cnt_reg;
    logic [1:0]           vote_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_bit_reg;
    logic                 fe_acc_reg;

    logic [DATA_BITS-1:0] data_out_reg;
    logic                 data_valid_reg, rx_busy_reg, frame_err_reg, parity_err_reg;
    logic                 overrun_err_reg, break_det_reg;

    logic tick, restart, sample_pt, bit_end, bit_val, is_break;
    logic complete, brk_hit, data_xor, parity_bad;

    uart_baud_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .restart (restart),
        .tick    (tick)
    );

    assign sample_pt  = tick && (os_cnt_reg == OS_VOTE2);
    assign bit_end    = tick && (os_cnt_reg == OS_LAST);
    // Majority of the two stored samples and the live third sample.
    assign bit_val    = (vote_reg[0] & vote_reg[1]) | (vote_reg[0] & rx_s_reg) | (vote_reg[1] & rx_s_reg);
    assign is_break   = (shift_reg == '0) && (PARITY == PAR_NONE || !par_bit_reg) && !bit_val;
    assign data_xor   = (^shift_reg) ^ par_bit_reg;
    assign parity_bad = (PARITY == PAR_ODD)  ? !data_xor :
                        (PARITY == PAR_EVEN) ?  data_xor : 1'b0;

    always_comb begin
        state_next = state_reg;
        restart    = 1'b0;
        complete   = 1'b0;
        brk_hit    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (rx_prev_reg && !rx_s_reg) begin
                    state_next = ST_START;
                    restart    = 1'b1;
                end
            end
            ST_START: begin
                if (sample_pt && bit_val) begin
                    state_next = ST_IDLE;
                end else if (bit_end) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end && bit_cnt_reg == DATA_LAST) begin
                    state_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                // Finish at the sample point so a back-to-back start edge is still seen.
                if (sample_pt) begin
                    if (bit_cnt_reg == '0 && is_break) begin
                        brk_hit    = 1'b1;
                        state_next = ST_BREAK_WAIT;
                    end else if (bit_cnt_reg == STOP_LAST) begin
                        complete   = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_BREAK_WAIT: begin
                if (rx_s_reg) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
            rx_prev_reg <= 1'b1;
            state_reg   <= ST_IDLE;
            os_cnt_reg  <= '0;
            bit_cnt_reg <= '0;
            vote_reg    <= '0;
            shift_reg   <= '0;
            par_bit_reg <= 1'b0;
            fe_acc_reg  <= 1'b0;
        end else begin
            rx_meta_reg <= rx_line;
            rx_s_reg    <= rx_meta_reg;
            rx_prev_reg <= rx_s_reg;
            state_reg   <= state_next;

            if (restart || state_reg == ST_IDLE) begin
                os_cnt_reg <= '0;
            end else if (tick) begin
                os_cnt_reg <= (os_cnt_reg == OS_LAST) ? '0 : os_cnt_reg + 1'b1;
            end

            if (state_next != state_reg) begin
                bit_cnt_reg <= '0;
            end else if (bit_end) begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end

            if (tick && os_cnt_reg == OS_VOTE0) begin
                vote_reg[0] <= rx_s_reg;
            end
            if (tick && os_cnt_reg == OS_VOTE1) begin
                vote_reg[1] <= rx_s_reg;
            end

            if (state_reg == ST_DATA && sample_pt) begin
                shift_reg <= {bit_val, shift_reg[DATA_BITS-1:1]};
            end
            if (state_reg == ST_PARITY && sample_pt) begin
                par_bit_reg <= bit_val;
            end

            if (restart) begin
                fe_acc_reg <= 1'b0;
            end else if (state_reg == ST_STOP && sample_pt && !bit_val) begin
                fe_acc_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_out_reg    <= '0;
            data_valid_reg  <= 1'b0;
            rx_busy_reg     <= 1'b0;
            frame_err_reg   <= 1'b0;
            parity_err_reg  <= 1'b0;
            overrun_err_reg <= 1'b0;
            break_det_reg   <= 1'b0;
        end else begin
            rx_busy_reg     <= (state_next != ST_IDLE);
            overrun_err_reg <= 1'b0;
            break_det_reg   <= brk_hit;

            if (data_valid_reg && data_ready) begin
                data_valid_reg <= 1'b0;
            end

            if (complete) begin
                if (!data_valid_reg || data_ready) begin
                    data_out_reg   <= shift_reg;
                    frame_err_reg  <= fe_acc_reg | !bit_val;
                    parity_err_reg <= parity_bad;
                    data_valid_reg <= 1'b1;
                end else begin
                    overrun_err_reg <= 1'b1;
                end
            end
        end
    end

    assign data_out    = data_out_reg;
    assign data_valid  = data_valid_reg;
    assign rx_busy     = rx_busy_reg;
    assign frame_err   = frame_err_reg;
    assign parity_err  = parity_err_reg;
    assign overrun_err = overrun_err_reg;
    assign break_det   = break_det_reg;

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised, oversampling UART receiver and the next generation of the team's fixed 8N1 receiver. It supports 5–9 data bits, optional odd/even parity, 1 or 2 stop bits, majority-vote sampling, line synchronisation, break detection and a valid/ready output handshake with overrun reporting. It sits between the pad-side rx_line and any byte-stream consumer, for example a FIFO or a register bridge.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD_RATE, 9600, line bit rate in baud
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY, 0, parity mode: 0 none, 1 odd, 2 even
STOP_BITS, 1, stop bits per frame: 1 or 2
OVERSAMPLE, 16, sample ticks per bit; even, at least 8
TICK_DIV (localparam), CLK_FREQ/(BAUD_RATE*OVERSAMPLE), clocks per tick; elaboration error if less than 1

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  synchronous active-low reset
rx_line  in  1  asynchronous serial input; idle high
data_out  out  DATA_BITS  received word, LSB = first bit received
data_valid  out  1  data_out and its status flags are valid
data_ready  in  1  consumer accepts the word
rx_busy  out  1  a frame is in progress
frame_err  out  1  status of held word: a stop bit was sampled 0
parity_err  out  1  status of held word: parity mismatch; always 0 when PARITY=0
overrun_err  out  1  1-cycle pulse: a completed frame was dropped
break_det  out  1  1-cycle pulse: break condition detected

Behaviour:
- Reset: the single clock is clk. reset_n is synchronous and active-low: sampled only on the rising edge of clk, and asserted when low.
  - All outputs go to 0.
  - The 2-FF synchronizer loads 1s, the FSM goes to IDLE, and the tick counter is cleared.
  - Reset mid-frame abandons the frame with no flags raised.
- Synchronizer: rx_line passes through 2 flops (rx_s). All logic uses rx_s only.
- Tick: the counter wraps at TICK_DIV-1 and emits a 1-cycle tick. It free-runs in IDLE and restarts at 0 when START is entered.
- Sampling: each bit is OVERSAMPLE ticks long. The bit value is the majority of rx_s at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 within the bit.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
  - IDLE: on a falling edge of rx_s (previous value 1, current 0), go to START and set rx_busy=1.
  - START: on the majority sample, a 0 continues; a 1 is a false start, so return to IDLE with rx_busy=0 and no flags.
  - After the final tick of START, go to DATA.
  - DATA: shift DATA_BITS bits, LSB first, into the shift register. Then go to PARITY if PARITY≠0, else to STOP.
  - PARITY: compare the sampled bit with the computed parity. Odd: the XOR of data bits plus the parity bit must be 1. Even: that XOR must be 0.
  - STOP: sample STOP_BITS bits; any 0 sets the frame error. The frame completes at the sample point of the last stop bit, without waiting out the rest of the bit, so the next start edge is not missed.
  - Break: all data bits 0, the parity bit 0 (if present) and the first stop bit 0 together mean a break. Pulse break_det, load no data word, go to BREAK_WAIT.
  - BREAK_WAIT: stay until rx_s=1, then go to IDLE with rx_busy=0.
- Completion:
  - If data_valid=0, or data_valid=1 and data_ready=1 in the same cycle, then in the cycle after the final stop sample: load data_out, frame_err and parity_err; set data_valid=1; clear rx_busy.
  - If data_valid=1 and data_ready=0: discard the new frame, keep the old word and flags, pulse overrun_err, clear rx_busy.
- Handshake:
  - data_valid stays high, and data_out and the flags stay stable, until a cycle with data_valid and data_ready both high.
  - In that cycle's next edge, data_valid falls unless a new word loads simultaneously.
  - data_ready while data_valid=0 is ignored.
- Latency: data_valid rises 1 clk after the final stop-bit sample tick (plus 2 clk of synchronizer delay relative to the pin).

Decomposition:
- Package uart_pkg holds:
  - the parity mode constants PAR_NONE, PAR_ODD, PAR_EVEN;
  - the FSM state enum;
  - a constant function for TICK_DIV with a range check.
- One sub-module, uart_baud_tick: the tick counter with a restart input and a tick output, reusable by a future TX.
- Majority vote and parity stay inline.

Test Plan:
Bench settings: CLK_FREQ=32000000, BAUD_RATE=1000000, OVERSAMPLE=16, so TICK_DIV=2 and 32 clk per bit.
1. 8N1, send 0xA5 with data_ready=1 → data_out=0xA5, data_valid high for 1 cycle, frame_err=0, parity_err=0.
2. PARITY=2, DATA_BITS=7: send 0x35 with a correct parity bit of 0, then 0x35 with parity bit 1 → first word has parity_err=0, second 0x35 has parity_err=1.
3. 8N2: send 0x3C with the second stop bit 0 → data_out=0x3C, frame_err=1.
4. Hold data_ready=0 and send 0x11 then 0x22 → data_out stays 0x11, overrun_err pulses once after the second frame. Raise data_ready → data_valid drops.
5. rx_line low for 12 bit times, then high → break_det pulses once, no data_valid, rx_busy clears only after the line returns high. A 0.3-bit low glitch → no activity (false start).
6. Deassert reset_n mid-DATA → all outputs 0 on the next edge. A clean 0x5A sent afterwards is received correctly.
